mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
- Two-requester arbiter that lets the CPU's instruction-fetch port (IFU) and load/store port (LSU) share one memory port.
- Sits between `cpu` and the single SRAM/bus adapter.
- Registers the winning request, issues it with a valid/ready handshake, waits for the response and routes it back to its owner.
- Only one transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wmask width is DATA_W/8.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only when the optional feature is compiled in.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ifu_reqValid  in  1  IFU request; held with ifu_addr stable until ifu_respValid.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_respValid  out  1  one-cycle response pulse to IFU.
- ifu_rdata  out  DATA_W  fetch data; valid with ifu_respValid.
- lsu_reqValid  in  1  LSU request; held with all lsu_* fields stable until lsu_respValid.
- lsu_addr  in  ADDR_W  load/store address.
- lsu_size  in  2  access size.
- lsu_wen  in  1  1 = store.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  DATA_W/8  byte strobes.
- lsu_respValid  out  1  one-cycle response pulse to LSU.
- lsu_rdata  out  DATA_W  load data.
- mem_reqValid  out  1  request to memory.
- mem_reqReady  in  1  memory accepts the request.
- mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask  out  as LSU  registered request payload.
- mem_respValid  in  1  one-cycle response pulse from memory.
- mem_rdata  in  DATA_W  response data.
- err  out  1  sticky error flag; constant 0 unless ARB_TIMEOUT_EN.

Behaviour:
- FSM states: IDLE, REQ, WAIT. Owner register: IFU or LSU. last_grant register: reset value IFU.
- Reset values: state = IDLE, mem_reqValid = 0, both respValids = 0, err = 0, payload registers = 0.
- Reset taken mid-transaction abandons the transaction. A mem_respValid that arrives later in IDLE is discarded and not forwarded.
- IDLE, grant rules:
  - Only one reqValid high: that requester wins.
  - Both high: the requester not equal to last_grant wins (round-robin). First tie after reset goes to LSU.
- IDLE, on grant:
  - Latch the payload. An IFU grant forces size = 2'b10, wen = 0, wdata = 0, wmask = 0.
  - Set owner and last_grant, go to REQ.
  - Grant to mem_reqValid latency is 1 cycle.
- REQ:
  - mem_reqValid = 1; payload is held stable.
  - When mem_reqReady = 1, go to WAIT.
  - mem_respValid in REQ or in the acceptance cycle is a protocol violation: ignore it; the bench asserts it never happens.
- WAIT:
  - mem_reqValid = 0.
  - When mem_respValid = 1: owner_respValid = 1 and owner_rdata = mem_rdata, combinational, same cycle. Then go to IDLE.
  - The other requester's respValid stays 0.
  - rdata to a non-owner is 0.
- A new grant is possible in the cycle after a response.
  - Requesters drop reqValid after respValid (cpu's sm is registered), so the same request is never re-granted.
  - Minimum transaction: grant cycle + 1 REQ cycle + 1 WAIT cycle = 3 cycles per access.
- reqValid dropping before response: not allowed; the latched request still completes and its response is delivered.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter is cleared on entry to REQ and counts each cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES: owner_respValid = 1, owner_rdata = 32'hDEAD_BEEF, err <= 1 (sticky until reset), state returns to IDLE.
  - A subsequent stray mem_respValid in IDLE is discarded.
- When not defined: no counter, err tied to 0, transactions wait indefinitely.

Decomposition:
- Shared package `arb_pkg` holds:
  - state enum: ARB_IDLE, ARB_REQ, ARB_WAIT.
  - owner enum: OWN_IFU, OWN_LSU.
  - constants: IFU_SIZE = 2'b10, ERR_RDATA = 32'hDEAD_BEEF.
- The existing size codes come from defs.vh.
- One sub-module, `arb_rr2`: combinational 2-way round-robin picker with inputs req[1:0] and last and output grant[1:0]; state stays in mem_arb.

Test Plan:
- IFU alone, ifu_addr = 0x8000_0000; mem_reqReady high; mem_respValid 2 cycles after accept with rdata = 0x0010_0093 -> mem_size = 2'b10, mem_wen = 0; ifu_respValid for 1 cycle with rdata 0x0010_0093; lsu_respValid stays 0.
- LSU store sw, addr 0x8000_0104, wdata 0x1234_5678, wmask 4'hF -> mem payload matches exactly and is stable while mem_reqReady is held low for 3 cycles; lsu_respValid once.
- Both requesting from reset, then both again -> grant order LSU, IFU; each respValid goes only to its owner.
- Reset asserted in WAIT, then mem_respValid the next cycle -> no respValid; state IDLE; mem_reqValid = 0.
- Back-to-back IFU requests -> second mem_reqValid starts exactly 2 cycles after the first response.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 8 and memory never responding -> owner gets respValid with 0xDEAD_BEEF on cycle 8; err = 1 and stays 1 until reset.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter (mem_arb).
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_REQ  = 2'b01,
    ARB_WAIT = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  // Instruction fetches are always full-word reads.
  localparam logic [1:0]  IFU_SIZE  = 2'b10;
  // Data returned to the owner when the watchdog abandons a transaction.
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  // Map a one-hot grant vector (bit0 = IFU, bit1 = LSU) to the owner it selects.
  function automatic arb_owner_e grant_to_owner(input logic [1:0] grant);
    return grant[1] ? OWN_LSU : OWN_IFU;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Combinational 2-way round-robin picker. req/grant bit0 = IFU, bit1 = LSU.
// On a tie the requester that was not granted last time wins; the history
// register itself lives in the parent.
module arb_rr2
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  arb_owner_e last,
  output logic [1:0] grant
);

  // Pick a single winner from the current requests.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == OWN_IFU) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arb.sv
// Two-requester (IFU / LSU) arbiter sharing one memory port. One transaction
// is outstanding at a time: IDLE grants and latches a request, REQ offers it
// with valid/ready, WAIT forwards the memory response to the owner.
// Optional feature macro: ARB_TIMEOUT_EN adds a watchdog that ends a stuck
// transaction after TIMEOUT_CYCLES with ERR_RDATA and a sticky err flag.
module mem_arb
  import arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_reqValid,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_reqValid,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [1:0]          lsu_size,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_reqValid,
  input  logic                mem_reqReady,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [1:0]          mem_size,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_respValid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err
);

  arb_state_e          state_r;
  arb_state_e          state_nxt_s;
  arb_owner_e          owner_r;
  arb_owner_e          last_grant_r;
  logic                req_valid_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [1:0]          size_r;
  logic                wen_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W/8-1:0] wmask_r;

  logic [1:0]          grant_s;
  logic                grant_any_s;
  arb_owner_e          grant_owner_s;
  logic                resp_fire_s;
  logic [DATA_W-1:0]   resp_data_s;
  logic                timeout_s;

  arb_rr2 u_rr (
    .req   ({lsu_reqValid, ifu_reqValid}),
    .last  (last_grant_r),
    .grant (grant_s)
  );

  assign grant_any_s   = (state_r == ARB_IDLE) && (grant_s != 2'b00);
  assign grant_owner_s = grant_to_owner(grant_s);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_r;
  logic             err_r;
  logic             tmo_take_s;

  // Fires in the TIMEOUT_CYCLES-th cycle spent in REQ/WAIT.
  assign timeout_s  = (state_r != ARB_IDLE) &&
                      ((32'(tmo_cnt_r) + 32'd1) == 32'(TIMEOUT_CYCLES));
  // A real response in the same cycle wins over the watchdog.
  assign tmo_take_s = timeout_s && !((state_r == ARB_WAIT) && mem_respValid);
  assign err        = err_r;

  // Watchdog counter (cleared while idle, so it starts at 0 in the first REQ cycle) and sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt_r <= '0;
      err_r     <= 1'b0;
    end else begin
      if ((state_r == ARB_IDLE) || tmo_take_s) begin
        tmo_cnt_r <= '0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
      end
      if (tmo_take_s) begin
        err_r <= 1'b1;
      end
    end
  end
`else
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state and response generation for the IDLE/REQ/WAIT sequencer.
  always_comb begin
    state_nxt_s = state_r;
    resp_fire_s = 1'b0;
    resp_data_s = '0;
    case (state_r)
      ARB_IDLE: begin
        if (grant_any_s) begin
          state_nxt_s = ARB_REQ;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_REQ: begin
        // A response while the request is still being offered is ignored.
        if (timeout_s) begin
          resp_fire_s = 1'b1;
          resp_data_s = DATA_W'(ERR_RDATA);
          state_nxt_s = ARB_IDLE;
        end else if (mem_reqReady) begin
          state_nxt_s = ARB_WAIT;
        end else begin
          state_nxt_s = ARB_REQ;
        end
      end
      ARB_WAIT: begin
        if (mem_respValid) begin
          resp_fire_s = 1'b1;
          resp_data_s = mem_rdata;
          state_nxt_s = ARB_IDLE;
        end else if (timeout_s) begin
          resp_fire_s = 1'b1;
          resp_data_s = DATA_W'(ERR_RDATA);
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_WAIT;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // State, owner, round-robin history and the latched request payload.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ARB_IDLE;
      owner_r      <= OWN_IFU;
      last_grant_r <= OWN_IFU;
      req_valid_r  <= 1'b0;
      addr_r       <= '0;
      size_r       <= 2'b00;
      wen_r        <= 1'b0;
      wdata_r      <= '0;
      wmask_r      <= '0;
    end else begin
      state_r     <= state_nxt_s;
      req_valid_r <= (state_nxt_s == ARB_REQ);
      if (grant_any_s) begin
        owner_r      <= grant_owner_s;
        last_grant_r <= grant_owner_s;
        if (grant_owner_s == OWN_LSU) begin
          addr_r  <= lsu_addr;
          size_r  <= lsu_size;
          wen_r   <= lsu_wen;
          wdata_r <= lsu_wdata;
          wmask_r <= lsu_wmask;
        end else begin
          addr_r  <= ifu_addr;
          size_r  <= IFU_SIZE;
          wen_r   <= 1'b0;
          wdata_r <= '0;
          wmask_r <= '0;
        end
      end
    end
  end

  assign mem_reqValid  = req_valid_r;
  assign mem_addr      = addr_r;
  assign mem_size      = size_r;
  assign mem_wen       = wen_r;
  assign mem_wdata     = wdata_r;
  assign mem_wmask     = wmask_r;

  // Responses are routed combinationally to the owner only; the other side sees zeros.
  assign ifu_respValid = resp_fire_s && (owner_r == OWN_IFU);
  assign lsu_respValid = resp_fire_s && (owner_r == OWN_LSU);
  assign ifu_rdata     = ifu_respValid ? resp_data_s : '0;
  assign lsu_rdata     = lsu_respValid ? resp_data_s : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: directed stimulus pushes expected memory
// requests and expected responses into queues; a negedge monitor pops and
// compares whenever the DUT presents a request or a response.
// Define ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES = 8).
module tb_mem_arb;
  import arb_pkg::*;

  localparam int TMO = 8;

  typedef struct {
    logic        lsu;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ifu_reqValid = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [1:0]  lsu_size = 2'b00;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        mem_reqValid;
  logic        mem_reqReady = 1'b0;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        err;

  int    vec_cnt = 0;
  int    mis_cnt = 0;
  int    cyc = 0;
  int    last_resp_cyc = 0;
  int    resp_count = 0;
  resp_t resp_q[$];
  req_t  req_q[$];

  mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
    .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata),
    .mem_reqValid(mem_reqValid), .mem_reqReady(mem_reqReady),
    .mem_addr(mem_addr), .mem_size(mem_size), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_respValid(mem_respValid), .mem_rdata(mem_rdata),
    .err(err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_req(input logic [31:0] a, input logic [1:0] s, input logic w,
                          input logic [31:0] d, input logic [3:0] m);
    req_t r;
    r.addr = a; r.size = s; r.wen = w; r.wdata = d; r.wmask = m;
    req_q.push_back(r);
  endtask

  task automatic push_resp(input logic is_lsu, input logic [31:0] d);
    resp_t r;
    r.lsu = is_lsu; r.rdata = d;
    resp_q.push_back(r);
  endtask

  // Wait (bounded) until the DUT offers a memory request; report its cycle.
  task automatic wait_mem_req(output int c);
    int n;
    n = 0;
    while (!mem_reqValid && n < 20) begin
      step();
      n++;
    end
    if (!mem_reqValid) chk("wait_mem_req_timeout", 96'd0, 96'd1);
    c = cyc;
  endtask

  // Memory side: hold ready low rdy_lat cycles, accept, then answer after rsp_lat WAIT cycles.
  task automatic serve(input int rdy_lat, input int rsp_lat, input logic [31:0] d);
    repeat (rdy_lat) step();
    mem_reqReady = 1'b1;
    step();
    mem_reqReady = 1'b0;
    repeat (rsp_lat) step();
    mem_respValid = 1'b1;
    mem_rdata = d;
    step();
    mem_respValid = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifu_reqValid = 1'b0;
    lsu_reqValid = 1'b0;
    mem_reqReady = 1'b0;
    mem_respValid = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  // Monitor: compare offered requests (every cycle, so payload stability is checked) and responses.
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_reqValid) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 96'd1, 96'd0);
        end else begin
          chk("req_payload", {mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask},
              {req_q[0].addr, req_q[0].size, req_q[0].wen, req_q[0].wdata, req_q[0].wmask});
          if (mem_reqReady) void'(req_q.pop_front());
        end
      end
      if (ifu_respValid || lsu_respValid) begin
        last_resp_cyc = cyc;
        resp_count++;
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", {ifu_respValid, lsu_respValid}, 96'd0);
        end else begin
          resp_t e;
          e = resp_q.pop_front();
          chk("resp_owner", {lsu_respValid, ifu_respValid}, e.lsu ? 96'd2 : 96'd1);
          chk("resp_rdata", e.lsu ? lsu_rdata : ifu_rdata, e.rdata);
          chk("nonowner_rdata", e.lsu ? ifu_rdata : lsu_rdata, 96'd0);
        end
      end
      if (mem_respValid) chk("resp_during_req", mem_reqValid, 96'd0);
    end
  end

  initial begin
    int c;
    do_reset();

    // Reset state.
    @(negedge clock);
    chk("rst_mem_reqValid", mem_reqValid, 96'd0);
    chk("rst_payload", {mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask}, 96'd0);
    chk("rst_respValid", {ifu_respValid, lsu_respValid}, 96'd0);
    chk("rst_err", err, 96'd0);
    step();

    // 1: IFU fetch alone.
    ifu_addr = 32'h8000_0000;
    ifu_reqValid = 1'b1;
    push_req(32'h8000_0000, 2'b10, 1'b0, 32'h0, 4'h0);
    push_resp(1'b0, 32'h0010_0093);
    wait_mem_req(c);
    serve(0, 1, 32'h0010_0093);
    ifu_reqValid = 1'b0;
    repeat (2) step();

    // 2: LSU store with ready held low for 3 cycles.
    lsu_addr = 32'h8000_0104; lsu_size = 2'b10; lsu_wen = 1'b1;
    lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hF;
    lsu_reqValid = 1'b1;
    push_req(32'h8000_0104, 2'b10, 1'b1, 32'h1234_5678, 4'hF);
    push_resp(1'b1, 32'h0);
    wait_mem_req(c);
    serve(3, 1, 32'h0);
    lsu_reqValid = 1'b0;
    repeat (2) step();

    // 3: both requesting right after reset -> LSU first, then IFU.
    do_reset();
    ifu_addr = 32'h8000_0010;
    lsu_addr = 32'h8000_0200; lsu_size = 2'b01; lsu_wen = 1'b0;
    lsu_wdata = 32'hAAAA_5555; lsu_wmask = 4'h3;
    ifu_reqValid = 1'b1;
    lsu_reqValid = 1'b1;
    push_req(32'h8000_0200, 2'b01, 1'b0, 32'hAAAA_5555, 4'h3);
    push_resp(1'b1, 32'hCAFE_0001);
    push_req(32'h8000_0010, 2'b10, 1'b0, 32'h0, 4'h0);
    push_resp(1'b0, 32'h0000_0013);
    wait_mem_req(c);
    serve(0, 1, 32'hCAFE_0001);
    lsu_reqValid = 1'b0;
    wait_mem_req(c);
    serve(0, 0, 32'h0000_0013);
    ifu_reqValid = 1'b0;
    repeat (2) step();

    // 4: reset in WAIT, then a late memory response in IDLE.
    ifu_addr = 32'h8000_0300;
    ifu_reqValid = 1'b1;
    push_req(32'h8000_0300, 2'b10, 1'b0, 32'h0, 4'h0);
    wait_mem_req(c);
    mem_reqReady = 1'b1;
    step();
    mem_reqReady = 1'b0;
    reset = 1'b1;
    ifu_reqValid = 1'b0;
    step();
    reset = 1'b0;
    mem_respValid = 1'b1;
    mem_rdata = 32'h5A5A_5A5A;
    @(negedge clock);
    chk("rst_wait_respValid", {ifu_respValid, lsu_respValid}, 96'd0);
    chk("rst_wait_reqValid", mem_reqValid, 96'd0);
    chk("rst_wait_state", dut.state_r, ARB_IDLE);
    step();
    mem_respValid = 1'b0;
    mem_rdata = '0;
    repeat (2) step();

    // 5: back-to-back IFU fetches; next request 2 cycles after the response.
    ifu_addr = 32'h8000_0020;
    ifu_reqValid = 1'b1;
    push_req(32'h8000_0020, 2'b10, 1'b0, 32'h0, 4'h0);
    push_resp(1'b0, 32'h1111_2222);
    wait_mem_req(c);
    serve(0, 0, 32'h1111_2222);
    ifu_addr = 32'h8000_0024;
    push_req(32'h8000_0024, 2'b10, 1'b0, 32'h0, 4'h0);
    push_resp(1'b0, 32'h3333_4444);
    wait_mem_req(c);
    chk("b2b_gap", 96'(c - last_resp_cyc), 96'd2);
    serve(0, 0, 32'h3333_4444);
    ifu_reqValid = 1'b0;
    repeat (2) step();

`ifdef ARB_TIMEOUT_EN
    // 6: memory never answers -> watchdog response on cycle TMO, sticky err.
    begin
      int c0;
      int before;
      int n;
      ifu_addr = 32'h8000_0400;
      ifu_reqValid = 1'b1;
      push_req(32'h8000_0400, 2'b10, 1'b0, 32'h0, 4'h0);
      push_resp(1'b0, 32'hDEAD_BEEF);
      before = resp_count;
      wait_mem_req(c0);
      n = 0;
      while (resp_count == before && n < 40) begin
        step();
        n++;
      end
      ifu_reqValid = 1'b0;
      chk("tmo_seen", 96'(resp_count - before), 96'd1);
      chk("tmo_cycle", 96'(last_resp_cyc - c0), 96'(TMO - 1));
      req_q.delete();
      @(negedge clock);
      chk("tmo_err_set", err, 96'd1);
      step();
      mem_respValid = 1'b1;
      mem_rdata = 32'h7777_7777;
      step();
      mem_respValid = 1'b0;
      repeat (3) step();
      @(negedge clock);
      chk("tmo_err_sticky", err, 96'd1);
      step();
      do_reset();
      @(negedge clock);
      chk("tmo_err_cleared", err, 96'd0);
      step();
    end
`else
    @(negedge clock);
    chk("err_tied_low", err, 96'd0);
    step();
`endif

    repeat (2) step();
    chk("resp_q_drained", 96'(resp_q.size()), 96'd0);
    chk("req_q_drained", 96'(req_q.size()), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
